// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the RV32I immediate encoder and extender.
// Holds the ImmSrc encodings, the instruction bits owned by each immediate
// format, and a helper that checks a sign run for representability.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Instruction bits carrying the immediate in each format
    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J  = 32'hFFFF_F000;

    // True when v[31:lsb] are all equal, i.e. v fits a signed field whose MSB is bit lsb
    function automatic logic sign_run_ok(input logic [31:0] v, input logic [4:0] lsb);
        logic [31:0] t;
        t = 32'($signed(v) >>> lsb);
        return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_encoder_field_pack.sv
// Combinational packer: scatters a signed immediate into the I/S/B/J bit
// positions of an instruction word, clearing the immediate-owned bits of the
// base word first. Out-of-range or misaligned immediates leave the immediate
// fields zero and raise imm_err.
module imm_field_pack
    import imm_pkg::*;
(
    input  logic [31:0] imm,
    input  logic [1:0]  imm_src,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        imm_err
);

    logic        range_ok_s;
    logic [31:0] field_s;
    logic [31:0] mask_s;

    // Select format: range/alignment check, scattered field, owned-bit mask
    always_comb begin
        range_ok_s = 1'b0;
        field_s    = 32'h0000_0000;
        mask_s     = MASK_I;
        case (imm_src)
            IMM_I: begin
                range_ok_s = sign_run_ok(imm, 5'd11);
                field_s    = {imm[11:0], 20'h00000};
                mask_s     = MASK_I;
            end
            IMM_S: begin
                range_ok_s = sign_run_ok(imm, 5'd11);
                field_s    = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
                mask_s     = MASK_SB;
            end
            IMM_B: begin
                range_ok_s = sign_run_ok(imm, 5'd12) && (imm[0] == 1'b0);
                field_s    = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
                mask_s     = MASK_SB;
            end
            IMM_J: begin
                range_ok_s = sign_run_ok(imm, 5'd20) && (imm[0] == 1'b0);
                field_s    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
                mask_s     = MASK_J;
            end
            default: begin
                range_ok_s = 1'b0;
                field_s    = 32'h0000_0000;
                mask_s     = MASK_I;
            end
        endcase
    end

    // Merge: masked base word plus the immediate field only when representable
    always_comb begin
        imm_err = 1'b0;
        instr   = base & ~mask_s;
        if (range_ok_s) begin
            instr = (base & ~mask_s) | field_s;
        end else begin
            imm_err = 1'b1;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: two-stage valid/ready pipeline that packs a signed
// immediate into a base instruction word (S1 = captured request, S2 = packed
// result). Optional statistics counters are enabled with IMM_ENC_STATS_EN.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Imm,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] BaseInstr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Instr,
    output logic        imm_err
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic        s1_valid_r;
    logic [31:0] s1_imm_r;
    logic [1:0]  s1_src_r;
    logic [31:0] s1_base_r;
    logic        s2_valid_r;
    logic [31:0] instr_r;
    logic        err_r;
    logic        s2_adv_s;
    logic [31:0] pk_instr_s;
    logic        pk_err_s;

    // S2 may load when empty or when its word leaves this cycle
    assign s2_adv_s  = !s2_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || s2_adv_s;
    assign out_valid = s2_valid_r;
    assign Instr     = instr_r;
    assign imm_err   = err_r;

    // S1: capture the request whenever the stage is free or drains into S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_imm_r   <= 32'h0000_0000;
            s1_src_r   <= 2'b00;
            s1_base_r  <= 32'h0000_0000;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_imm_r  <= Imm;
                s1_src_r  <= ImmSrc;
                s1_base_r <= BaseInstr;
            end
        end
    end

    imm_field_pack u_pack (
        .imm     (s1_imm_r),
        .imm_src (s1_src_r),
        .base    (s1_base_r),
        .instr   (pk_instr_s),
        .imm_err (pk_err_s)
    );

    // S2: register the packed word; held stable while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            instr_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                instr_r <= pk_instr_s;
                err_r   <= pk_err_s;
            end
        end
    end

`ifdef IMM_ENC_STATS_EN
    logic out_fire_s;
    assign out_fire_s = s2_valid_r && out_ready;

    // Saturating counts of emitted words and of emitted words flagged in error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (out_fire_s) begin
            if (enc_cnt != {CNT_W{1'b1}}) begin
                enc_cnt <= enc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (err_r && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed format vectors, latency,
// backpressure, reset with words in flight, and random round-trip through a
// bench-side immediate extender. Scoreboard queue holds expected words.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Imm;
    logic [1:0]  ImmSrc;
    logic [31:0] BaseInstr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Instr;
    logic        imm_err;
`ifdef IMM_ENC_STATS_EN
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;
`endif

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Imm       (Imm),
        .ImmSrc    (ImmSrc),
        .BaseInstr (BaseInstr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Instr     (Instr),
        .imm_err   (imm_err)
`ifdef IMM_ENC_STATS_EN
        ,
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  src;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        exp_err;
        int          t_acc;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_emit = 0;
    int   n_emit_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: representable range per format
    function automatic logic model_err(input logic [31:0] v, input logic [1:0] src);
        longint s;
        s = longint'($signed(v));
        case (src)
            2'b00, 2'b01: return !(s >= -2048 && s <= 2047);
            2'b10:        return !(s >= -4096 && s <= 4095 && v[0] == 1'b0);
            default:      return !(s >= -1048576 && s <= 1048575 && v[0] == 1'b0);
        endcase
    endfunction

    // Bench-side immediate extender (decoder direction)
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] src);
        case (src)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] owned(input logic [1:0] src);
        case (src)
            2'b00:   return 32'hFFF00000;
            2'b11:   return 32'hFFFFF000;
            default: return 32'hFE000F80;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Imm = 32'h0; ImmSrc = 2'b00; BaseInstr = 32'h0;
        step();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || Instr !== 32'h0 || imm_err !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: out_valid=%b Instr=%h imm_err=%b in_ready=%b, want 0/00000000/0/1",
                     out_valid, Instr, imm_err, in_ready);
        end
`ifdef IMM_ENC_STATS_EN
        n_cmp++;
        if (enc_cnt !== 16'h0 || err_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_counters: enc=%0d err=%0d, want 0/0", enc_cnt, err_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [31:0] v_imm[6]   = '{32'hFFFFF800, 32'h000007FF, 32'hFFFFF000, 32'h00000801, 32'h00000800, 32'h00000800};
        logic [1:0]  v_src[6]   = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [31:0] v_base[6]  = '{32'h13, 32'h2023, 32'h63, 32'h63, 32'h6F, 32'h13};
        logic [31:0] v_instr[6] = '{32'h80000013, 32'h7E002FA3, 32'h80000063, 32'h00000063, 32'h0010006F, 32'h00000013};
        logic        v_err[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int i = 0;
        int budget = 0;
        ent_t e;
        out_ready = 1'b1;
        while ((i < 6 || sb.size() > 0) && budget < 50) begin
            if (i < 6) begin
                in_valid = 1'b1; Imm = v_imm[i]; ImmSrc = v_src[i]; BaseInstr = v_base[i];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (Instr !== e.exp_instr || imm_err !== e.exp_err) begin
                    n_bad++;
                    $display("FAIL directed_word src=%b imm=%h: Instr=%h imm_err=%b, want %h/%b",
                             e.src, e.imm, Instr, imm_err, e.exp_instr, e.exp_err);
                end
                n_cmp++;
                if (cyc - e.t_acc !== 2) begin
                    n_bad++;
                    $display("FAIL directed_latency imm=%h: %0d cycles, want 2", e.imm, cyc - e.t_acc);
                end
            end
            if (in_valid && in_ready) begin
                e = '{v_imm[i], v_src[i], v_base[i], v_instr[i], v_err[i], cyc};
                sb.push_back(e);
                i++;
            end
            step();
            budget++;
        end
        in_valid = 1'b0;
        if (budget >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_directed: %0d words outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int budget = 0;
        logic [31:0] held;
        ent_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; Imm = 32'(k + 1); ImmSrc = 2'b00; BaseInstr = 32'h13;
            #1;
            if (in_valid && in_ready) begin
                e = '{Imm, 2'b00, 32'h13, {12'(k + 1), 20'h00013}, 1'b0, cyc};
                sb.push_back(e);
                k++;
            end
            step();
        end
        #1;
        n_cmp++;
        if (k !== 2 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept: accepted=%0d in_ready=%b, want 2/0", k, in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || Instr !== 32'h00100013) begin
            n_bad++;
            $display("FAIL bp_head: out_valid=%b Instr=%h, want 1/00100013", out_valid, Instr);
        end
        held = Instr;
        step();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || Instr !== held) begin
            n_bad++;
            $display("FAIL bp_hold: out_valid=%b Instr=%h, want 1/%h", out_valid, Instr, held);
        end
        @(negedge clk);
        out_ready = 1'b1;
        while ((k < 3 || sb.size() > 0) && budget < 40) begin
            if (k < 3) begin
                in_valid = 1'b1; Imm = 32'(k + 1); ImmSrc = 2'b00; BaseInstr = 32'h13;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (Instr !== e.exp_instr || imm_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_order: Instr=%h imm_err=%b, want %h/0", Instr, imm_err, e.exp_instr);
                end
            end
            if (in_valid && in_ready) begin
                e = '{Imm, 2'b00, 32'h13, {12'(k + 1), 20'h00013}, 1'b0, cyc};
                sb.push_back(e);
                k++;
            end
            step();
            budget++;
        end
        in_valid = 1'b0;
        if (budget >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_backpressure: %0d words outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; Imm = 32'h5; ImmSrc = 2'b01; BaseInstr = 32'h2023;
            step();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstfl_pre: out_valid=%b, want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || Instr !== 32'h0 || imm_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rstfl_async: out_valid=%b Instr=%h imm_err=%b, want 0/00000000/0",
                     out_valid, Instr, imm_err);
        end
`ifdef IMM_ENC_STATS_EN
        n_cmp++;
        if (enc_cnt !== 16'h0 || err_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL rstfl_counters: enc=%0d err=%0d, want 0/0", enc_cnt, err_cnt);
        end
`endif
        sb.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) seen++;
            step();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL rstfl_flush: %0d stale words, want 0", seen);
        end
    endtask

    task automatic test_round_trip();
        int sent = 0;
        int budget = 0;
        ent_t e;
        n_emit = 0; n_emit_err = 0;
        while ((sent < 300 || sb.size() > 0) && budget < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 300 && $urandom_range(0, 4) != 0) begin
                in_valid  = 1'b1;
                Imm       = 32'($signed($urandom) >>> $urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) Imm[0] = 1'b0;
                ImmSrc    = 2'($urandom_range(0, 3));
                BaseInstr = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rt_spurious: Instr=%h, want no output", Instr);
                end else begin
                    e = sb.pop_front();
                    n_emit++;
                    if (e.exp_err) n_emit_err++;
                    n_cmp++;
                    if (imm_err !== e.exp_err) begin
                        n_bad++;
                        $display("FAIL rt_err src=%b imm=%h: imm_err=%b, want %b", e.src, e.imm, imm_err, e.exp_err);
                    end
                    n_cmp++;
                    if ((Instr & ~owned(e.src)) !== (e.base & ~owned(e.src))) begin
                        n_bad++;
                        $display("FAIL rt_base src=%b base=%h: Instr=%h, want base bits %h",
                                 e.src, e.base, Instr, e.base & ~owned(e.src));
                    end
                    n_cmp++;
                    if (e.exp_err ? ((Instr & owned(e.src)) !== 32'h0) : (extend(Instr, e.src) !== e.imm)) begin
                        n_bad++;
                        $display("FAIL rt_imm src=%b imm=%h: Instr=%h extends to %h, want %h",
                                 e.src, e.imm, Instr, extend(Instr, e.src), e.exp_err ? 32'h0 : e.imm);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = '{Imm, ImmSrc, BaseInstr, 32'h0, model_err(Imm, ImmSrc), cyc};
                sb.push_back(e);
                sent++;
            end
            step();
            budget++;
        end
        in_valid = 1'b0;
        if (budget >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_round_trip: %0d words outstanding, want 0", sb.size());
            sb.delete();
        end
`ifdef IMM_ENC_STATS_EN
        n_cmp++;
        if (enc_cnt !== 16'(n_emit) || err_cnt !== 16'(n_emit_err)) begin
            n_bad++;
            $display("FAIL rt_counters: enc=%0d err=%0d, want %0d/%0d", enc_cnt, err_cnt, n_emit, n_emit_err);
        end
`endif
    endtask

    // Scenario sequence
    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_inflight();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
